boot_memory: RTL and testbench

BOOT_MEMORY -- requirements
Module: boot_memory

---
 rtl/boot_memory_pkg.sv | 13 +
 rtl/boot_memory_if.sv | 29 ++
 rtl/boot_memory_mem_array.sv | 27 ++
 rtl/boot_memory.sv | 96 +++++++++
 tb/tb_boot_memory.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/boot_memory_pkg.sv
// Shared definitions for the boot memory: word width, default geometry and
// loader FSM state encodings.
package boot_memory_pkg;
    localparam int WORD_W        = 16;
    localparam int DEPTH_DEFAULT = 65536;
    localparam int AW_DEFAULT    = 16;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } boot_state_e;
endpackage

// File: rtl/boot_memory_if.sv
// Processor and byte-loader bus of the boot memory; the master side is the
// processor plus loader, the slave side is the memory.
interface boot_memory_if;
    import boot_memory_pkg::*;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_in;
    logic [WORD_W-1:0] mem_out;
    logic              we;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              reload;
    logic              cpu_rst;
    logic [15:0]       ld_count;

    modport master (
        output pc, mem_addr, mem_out, we, ld_valid, ld_data, ld_last, reload,
        input  inst, mem_in, ld_ready, cpu_rst, ld_count
    );

    modport slave (
        input  pc, mem_addr, mem_out, we, ld_valid, ld_data, ld_last, reload,
        output inst, mem_in, ld_ready, cpu_rst, ld_count
    );
endinterface

// File: rtl/boot_memory_mem_array.sv
// Word storage with two combinational read ports and one clocked write port.
// Contents are deliberately never reset.
module mem_array #(
    parameter int DEPTH = 65536,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_a_addr_i,
    output logic [DW-1:0] rd_a_data_o,
    input  logic [AW-1:0] rd_b_addr_i,
    output logic [DW-1:0] rd_b_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i
);
    logic [DW-1:0] mem_q [DEPTH];

    assign rd_a_data_o = mem_q[rd_a_addr_i];
    assign rd_b_data_o = mem_q[rd_b_addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end
endmodule

// File: rtl/boot_memory.sv
// Boot memory: a byte loader fills the array while the processor is held in
// reset, then the processor runs with instruction and data ports on it.
module boot_memory
    import boot_memory_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    boot_memory_if.slave  bus
);
    boot_state_e       state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [AW-1:0]     ld_addr_q, ld_addr_d;
    logic [15:0]       ld_count_q, ld_count_d;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              xfer;

    assign bus.ld_ready = (state_q != RUN);
    assign bus.cpu_rst  = (state_q != RUN);
    assign bus.ld_count = ld_count_q;
    assign xfer         = bus.ld_valid && bus.ld_ready;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        ld_addr_d  = ld_addr_q;
        ld_count_d = ld_count_q;
        wr_en      = 1'b0;
        wr_addr    = ld_addr_q;
        wr_data    = {hi_q, bus.ld_data};
        case (state_q)
            LOAD_HI: begin
                if (xfer) begin
                    hi_d    = bus.ld_data;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (xfer) begin
                    wr_en      = 1'b1;
                    ld_addr_d  = ld_addr_q + 1'b1;
                    ld_count_d = (ld_count_q == 16'hFFFF) ? ld_count_q : ld_count_q + 16'd1;
                    state_d    = bus.ld_last ? RUN : LOAD_HI;
                end
            end
            RUN: begin
                // A write coinciding with reload still lands before loading resumes.
                if (bus.we) begin
                    wr_en   = 1'b1;
                    wr_addr = bus.mem_addr[AW-1:0];
                    wr_data = bus.mem_out;
                end
                if (bus.reload) begin
                    state_d    = LOAD_HI;
                    ld_addr_d  = '0;
                    ld_count_d = '0;
                end
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_HI;
            hi_q       <= '0;
            ld_addr_q  <= '0;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            ld_addr_q  <= ld_addr_d;
            ld_count_q <= ld_count_d;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (WORD_W)
    ) u_mem_array (
        .clk         (clk),
        .rd_a_addr_i (bus.pc[AW-1:0]),
        .rd_a_data_o (bus.inst),
        .rd_b_addr_i (bus.mem_addr[AW-1:0]),
        .rd_b_data_o (bus.mem_in),
        .wr_en_i     (wr_en && !rst),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data)
    );
endmodule

// File: tb/tb_boot_memory.sv
// Self-checking bench for boot_memory using a small 16-word instance so the
// address wrap can be reached quickly.
module tb_boot_memory;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    boot_memory_if bus ();

    boot_memory #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rdy;
        logic        crst;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic expect_word(input logic [15:0] addr, input logic [15:0] exp);
        rd_exp_t e;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.pc       = e.addr;
            bus.mem_addr = e.addr;
            #1;
            check($sformatf("inst[%0h]", e.addr), bus.inst, e.exp);
            check($sformatf("mem_in[%0h]", e.addr), bus.mem_in, e.exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
        bus.mem_addr = addr;
        bus.mem_out  = data;
        bus.we       = 1'b1;
        step();
        bus.we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.pc = '0; bus.mem_addr = '0; bus.mem_out = '0; bus.we = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0; bus.reload = 1'b0;

        // Loader vectors with valid toggling; last on a high byte must be ignored.
        tbl[0] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 16'd0};
        tbl[1] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[3] = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 16'd1};
        tbl[4] = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[5] = '{1'b0, 8'hDD, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[6] = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[7] = '{1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 16'd2};

        // Reset state
        do_reset();
        check("rst cpu_rst", 16'(bus.cpu_rst), 16'd1);
        check("rst ld_ready", 16'(bus.ld_ready), 16'd1);
        check("rst ld_count", bus.ld_count, 16'd0);

        // Basic four-byte load
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        check("load cpu_rst before last", 16'(bus.cpu_rst), 16'd1);
        send_byte(8'h78, 1'b1);
        check("load cpu_rst", 16'(bus.cpu_rst), 16'd0);
        check("load ld_ready", 16'(bus.ld_ready), 16'd0);
        check("load ld_count", bus.ld_count, 16'd2);
        expect_word(16'h0000, 16'h1234);
        expect_word(16'h0001, 16'h5678);
        drain();

        // Processor write: old value during the write cycle, new value after
        cpu_write(16'h0005, 16'h1111);
        cpu_write(16'h0007, 16'h7777);
        bus.mem_addr = 16'h0005;
        bus.pc       = 16'h0005;
        bus.mem_out  = 16'hBEEF;
        bus.we       = 1'b1;
        #1;
        check("wr same-cycle mem_in", bus.mem_in, 16'h1111);
        step();
        bus.we = 1'b0;
        check("wr next mem_in", bus.mem_in, 16'hBEEF);
        check("wr next inst", bus.inst, 16'hBEEF);

        // Clear words 0/1 so the toggled load must rewrite them
        cpu_write(16'h0000, 16'h0000);
        cpu_write(16'h0001, 16'h0000);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.ld_valid = tbl[i].v;
            bus.ld_data  = tbl[i].d;
            bus.ld_last  = tbl[i].l;
            step();
            check($sformatf("tog%0d ld_ready", i), 16'(bus.ld_ready), 16'(tbl[i].rdy));
            check($sformatf("tog%0d cpu_rst", i), 16'(bus.cpu_rst), 16'(tbl[i].crst));
            check($sformatf("tog%0d ld_count", i), bus.ld_count, tbl[i].cnt);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        expect_word(16'h0000, 16'h1234);
        expect_word(16'h0001, 16'h5678);
        drain();

        // Reset beats a processor write, then reset mid-load discards the half word
        bus.mem_addr = 16'h0007;
        bus.mem_out  = 16'hBAD0;
        bus.we       = 1'b1;
        rst          = 1'b1;
        step();
        bus.we = 1'b0;
        rst    = 1'b0;
        send_byte(8'hAA, 1'b0);
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        check("rstmid ld_count", bus.ld_count, 16'd1);
        check("rstmid cpu_rst", 16'(bus.cpu_rst), 16'd0);
        expect_word(16'h0000, 16'h1122);
        expect_word(16'h0001, 16'h5678);
        expect_word(16'h0007, 16'h7777);
        drain();

        // Reload together with a write; we and reload ignored during the load
        bus.mem_addr = 16'h0003;
        bus.mem_out  = 16'hCAFE;
        bus.we       = 1'b1;
        bus.reload   = 1'b1;
        step();
        check("reload cpu_rst", 16'(bus.cpu_rst), 16'd1);
        check("reload ld_ready", 16'(bus.ld_ready), 16'd1);
        check("reload ld_count", bus.ld_count, 16'd0);
        bus.mem_addr = 16'h0007;
        bus.mem_out  = 16'hDEAD;
        send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b1);
        bus.we     = 1'b0;
        bus.reload = 1'b0;
        check("reload2 ld_count", bus.ld_count, 16'd1);
        check("reload2 cpu_rst", 16'(bus.cpu_rst), 16'd0);
        expect_word(16'h0003, 16'hCAFE);
        expect_word(16'h0000, 16'h9ABC);
        expect_word(16'h0007, 16'h7777);
        drain();

        // Address wrap: 17 words into a 16-word array
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [15:0] w;
            w = 16'h1000 + 16'(i);
            send_byte(w[15:8], 1'b0);
            send_byte(w[7:0], (i == 16));
        end
        check("wrap ld_count", bus.ld_count, 16'd17);
        check("wrap cpu_rst", 16'(bus.cpu_rst), 16'd0);
        expect_word(16'h0000, 16'h1010);
        expect_word(16'h0001, 16'h1001);
        expect_word(16'h000F, 16'h100F);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
